// File: rtl/fifo_wr_front_pkg.sv
// Shared constants and helpers for the dual-clock FIFO write-side blocks.
// Imported by the front end, pointer, synchroniser and memory modules.
package fifo_wr_front_pkg;

    localparam int DSIZE_DEF        = 8;
    localparam int ADDRSIZE_DEF     = 4;
    localparam int AFULL_THRESH_DEF = 12;

    // Widest pointer the Gray helper handles; narrower pointers are zero-extended.
    localparam int GRAY_MAX_W = 16;

    typedef enum logic [1:0] {
        SKID_EMPTY = 2'd0,
        SKID_ONE   = 2'd1,
        SKID_TWO   = 2'd2
    } skid_state_e;

    // Leading zeros do not disturb the XOR prefix, so one width serves every pointer size.
    function automatic logic [GRAY_MAX_W-1:0] gray2bin(input logic [GRAY_MAX_W-1:0] g);
        logic [GRAY_MAX_W-1:0] b;
        b[GRAY_MAX_W-1] = g[GRAY_MAX_W-1];
        for (int i = GRAY_MAX_W - 2; i >= 0; i--) begin
            b[i] = b[i+1] ^ g[i];
        end
        return b;
    endfunction

endpackage

// File: rtl/fifo_wr_front_if.sv
// Producer stream plus write-pointer/memory side signals of the FIFO write front end.
interface fifo_wr_front_if
    import fifo_wr_front_pkg::*;
#(
    parameter int DSIZE    = DSIZE_DEF,
    parameter int ADDRSIZE = ADDRSIZE_DEF
);
    logic                s_valid;
    logic [DSIZE-1:0]    s_data;
    logic                s_ready;
    logic                wfull;
    logic [ADDRSIZE:0]   wptr;
    logic [ADDRSIZE:0]   wq2_rptr;
    logic                winc;
    logic [DSIZE-1:0]    wdata;
    logic [ADDRSIZE:0]   wlevel;
    logic                walmost_full;

    modport master (
        output s_valid, s_data, wfull, wptr, wq2_rptr,
        input  s_ready, winc, wdata, wlevel, walmost_full
    );

    modport slave (
        input  s_valid, s_data, wfull, wptr, wq2_rptr,
        output s_ready, winc, wdata, wlevel, walmost_full
    );

endinterface

// File: rtl/fifo_wr_front_wr_skid_buf.sv
// Two-entry in-order skid buffer between the producer and the FIFO write port.
//   state      | meaning
//   SKID_EMPTY | no words held, head invalid
//   SKID_ONE   | head valid, tail free
//   SKID_TWO   | head and tail valid, s_ready low
module wr_skid_buf
    import fifo_wr_front_pkg::*;
#(
    parameter int DSIZE = DSIZE_DEF
) (
    input  logic             wclk,
    input  logic             wrst_n,
    input  logic             s_valid,
    input  logic [DSIZE-1:0] s_data,
    output logic             s_ready,
    input  logic             drain,
    output logic             has_data,
    output logic [DSIZE-1:0] head_data
);

    skid_state_e      state;
    skid_state_e      state_next;
    logic [DSIZE-1:0] head_q;
    logic [DSIZE-1:0] tail_q;
    logic             accept;

    assign accept = s_valid & s_ready;

    // s_ready is registered from the next occupancy so it never depends on wfull.
    always_ff @(posedge wclk) begin
        if (!wrst_n) begin
            state   <= SKID_EMPTY;
            s_ready <= 1'b0;
        end else begin
            state   <= state_next;
            s_ready <= (state_next != SKID_TWO);
        end
    end

    always_comb begin
        state_next = state;
        unique case (state)
            SKID_EMPTY: begin
                if (accept) state_next = SKID_ONE;
            end
            SKID_ONE: begin
                if (accept && !drain)      state_next = SKID_TWO;
                else if (!accept && drain) state_next = SKID_EMPTY;
            end
            SKID_TWO: begin
                if (drain) state_next = SKID_ONE;
            end
            default: state_next = SKID_EMPTY;
        endcase
    end

    always_comb begin
        has_data  = (state != SKID_EMPTY);
        head_data = head_q;
    end

    always_ff @(posedge wclk) begin
        if (!wrst_n) begin
            head_q <= '0;
            tail_q <= '0;
        end else begin
            unique case (state)
                SKID_EMPTY: begin
                    if (accept) head_q <= s_data;
                end
                SKID_ONE: begin
                    if (accept && drain) head_q <= s_data;
                    else if (accept)     tail_q <= s_data;
                end
                SKID_TWO: begin
                    if (drain) head_q <= tail_q;
                end
                default: begin
                    head_q <= head_q;
                end
            endcase
        end
    end

endmodule

// File: rtl/fifo_wr_front.sv
// Write-domain front end: skid-buffered producer stream into the FIFO write port,
// plus a registered, conservative fill level and almost-full flag.
module fifo_wr_front
    import fifo_wr_front_pkg::*;
#(
    parameter int DSIZE        = DSIZE_DEF,
    parameter int ADDRSIZE     = ADDRSIZE_DEF,
    parameter int AFULL_THRESH = AFULL_THRESH_DEF
) (
    input logic              wclk,
    input logic              wrst_n,
    fifo_wr_front_if.slave   bus
);

    localparam int              PTR_W  = ADDRSIZE + 1;
    localparam logic [PTR_W-1:0] THRESH = PTR_W'(AFULL_THRESH);

    logic             has_data;
    logic [PTR_W-1:0] wptr_bin;
    logic [PTR_W-1:0] rptr_bin;
    logic [PTR_W-1:0] level_next;

    wr_skid_buf #(
        .DSIZE (DSIZE)
    ) u_skid (
        .wclk      (wclk),
        .wrst_n    (wrst_n),
        .s_valid   (bus.s_valid),
        .s_data    (bus.s_data),
        .s_ready   (bus.s_ready),
        .drain     (bus.winc),
        .has_data  (has_data),
        .head_data (bus.wdata)
    );

    // wfull gates the strobe combinationally; the pointer block needs it same-cycle.
    assign bus.winc = has_data & ~bus.wfull;

    assign wptr_bin   = PTR_W'(gray2bin(GRAY_MAX_W'(bus.wptr)));
    assign rptr_bin   = PTR_W'(gray2bin(GRAY_MAX_W'(bus.wq2_rptr)));
    assign level_next = wptr_bin - rptr_bin;

    always_ff @(posedge wclk) begin
        if (!wrst_n) begin
            bus.wlevel       <= '0;
            bus.walmost_full <= 1'b0;
        end else begin
            bus.wlevel       <= level_next;
            bus.walmost_full <= (level_next >= THRESH);
        end
    end

endmodule

// File: tb/tb_fifo_wr_front.sv
// Randomised scoreboard bench for fifo_wr_front against a queue-based reference model.
module tb_fifo_wr_front;

    localparam int DSIZE    = 8;
    localparam int ADDRSIZE = 4;
    localparam int AFULL    = 12;
    localparam int PTR_W    = ADDRSIZE + 1;
    localparam int PMOD     = 1 << PTR_W;

    logic wclk   = 1'b0;
    logic wrst_n = 1'b0;

    fifo_wr_front_if #(.DSIZE(DSIZE), .ADDRSIZE(ADDRSIZE)) bus ();

    fifo_wr_front #(
        .DSIZE        (DSIZE),
        .ADDRSIZE     (ADDRSIZE),
        .AFULL_THRESH (AFULL)
    ) dut (
        .wclk   (wclk),
        .wrst_n (wrst_n),
        .bus    (bus)
    );

    always #5 wclk = ~wclk;

    typedef struct {
        logic [PTR_W-1:0] lvl;
        logic             af;
    } lvl_t;

    logic [DSIZE-1:0] exp_q[$];
    lvl_t             lvl_q[$];
    int               checks = 0;
    int               errors = 0;
    bit               live   = 1'b0;
    int               wb     = 0;
    int               rb     = 0;
    int               writes = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
        end
    endtask

    function automatic logic [PTR_W-1:0] to_gray(input int b);
        logic [PTR_W-1:0] v;
        v = PTR_W'(b % PMOD);
        return v ^ (v >> 1);
    endfunction

    task automatic set_ptrs(input int w, input int r);
        wb = w % PMOD;
        rb = r % PMOD;
        bus.wptr     = to_gray(wb);
        bus.wq2_rptr = to_gray(rb);
    endtask

    // Model update at each edge: accepted words join the pending queue, level is plain modular distance.
    always @(posedge wclk) begin
        lvl_t e;
        if (!wrst_n) begin
            exp_q.delete();
            e.lvl = '0;
            e.af  = 1'b0;
        end else begin
            if (bus.s_valid && bus.s_ready) exp_q.push_back(bus.s_data);
            e.lvl = PTR_W'((wb - rb + PMOD) % PMOD);
            e.af  = (((wb - rb + PMOD) % PMOD) >= AFULL);
        end
        lvl_q.push_back(e);
        live = wrst_n;
    end

    always @(negedge wclk) begin
        bit   exp_winc;
        bit   exp_rdy;
        lvl_t e;
        exp_winc = (exp_q.size() != 0) && !bus.wfull;
        exp_rdy  = live && (exp_q.size() < 2);
        chk("winc", 32'(bus.winc), 32'(exp_winc));
        chk("s_ready", 32'(bus.s_ready), 32'(exp_rdy));
        if (!live) chk("wdata_reset", 32'(bus.wdata), 32'd0);
        else if (exp_q.size() != 0) chk("wdata", 32'(bus.wdata), 32'(exp_q[0]));
        if (exp_winc) void'(exp_q.pop_front());
        if (lvl_q.size() != 0) begin
            e = lvl_q.pop_front();
            chk("wlevel", 32'(bus.wlevel), 32'(e.lvl));
            chk("walmost_full", 32'(bus.walmost_full), 32'(e.af));
        end
    end

    task automatic step(output bit acc);
        @(posedge wclk);
        acc = bus.s_valid && bus.s_ready;
        if (bus.winc) writes++;
        #1;
    endtask

    task automatic idle(input int n);
        bit acc;
        repeat (n) step(acc);
    endtask

    task automatic send_seq(input int first, input int n, input int full_after, input int full_cycles);
        int sent  = 0;
        int wr0   = writes;
        int fc    = 0;
        int guard = 0;
        bit done  = 1'b0;
        bit acc;
        bus.s_valid = 1'b1;
        bus.s_data  = DSIZE'(first);
        while (sent < n && guard < 200) begin
            step(acc);
            guard++;
            if (acc) begin
                sent++;
                bus.s_data = DSIZE'(first + sent);
            end
            if (sent == n) bus.s_valid = 1'b0;
            if (full_after >= 0 && !done && (writes - wr0) >= full_after) begin
                fc++;
                bus.wfull = (fc <= full_cycles);
                if (fc > full_cycles) done = 1'b1;
            end
        end
        chk("send_complete", 32'(sent), 32'(n));
        bus.s_valid = 1'b0;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        bit acc;
        bus.s_valid = 1'b1;
        bus.s_data  = 8'hAA;
        bus.wfull   = 1'b0;
        set_ptrs(7, 1);
        wrst_n = 1'b0;
        idle(3);
        wrst_n = 1'b1;

        send_seq(8'h01, 16, -1, 0);
        idle(3);

        send_seq(8'h01, 16, 5, 6);
        bus.wfull = 1'b0;
        idle(3);

        set_ptrs(2, 30);
        idle(1);
        set_ptrs(28, 12);
        idle(1);
        set_ptrs(16, 5);
        idle(1);
        set_ptrs(17, 5);
        idle(1);
        set_ptrs(16, 5);
        idle(2);

        repeat (400) begin
            int r;
            bus.s_valid = 1'($urandom_range(0, 1));
            bus.s_data  = DSIZE'($urandom);
            bus.wfull   = ($urandom_range(0, 9) < 3);
            r = int'($urandom_range(0, PMOD - 1));
            set_ptrs(r + int'($urandom_range(0, 1 << ADDRSIZE)), r);
            step(acc);
        end
        bus.s_valid = 1'b0;
        bus.wfull   = 1'b0;
        idle(3);

        // Fill the buffer behind a full FIFO, then reset with both entries held.
        bus.wfull   = 1'b1;
        bus.s_valid = 1'b1;
        bus.s_data  = 8'h5A;
        idle(4);
        chk("held_ready_low", 32'(bus.s_ready), 32'd0);
        wrst_n = 1'b0;
        idle(1);
        wrst_n      = 1'b1;
        bus.wfull   = 1'b0;
        bus.s_valid = 1'b0;
        idle(6);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/fifo_wr_front.md
# fifo_wr_front

Write-domain front end for the dual-clock FIFO. It accepts a producer's valid/ready stream into a 2-entry skid buffer and drives `winc`/`wdata` into the write-pointer/full logic and memory, holding data whenever `wfull` is set. It also derives a registered, conservative write-side fill level and an almost-full flag from the Gray write pointer and the synchronised Gray read pointer.

## Interface
- `DSIZE`, 8: data width.
- `ADDRSIZE`, 4: FIFO address bits. Depth = 2^ADDRSIZE; pointers are ADDRSIZE+1 bits.
- `AFULL_THRESH`, 12: `walmost_full` asserts when level ≥ this value. Legal range 1..2^ADDRSIZE.

Ports:
- `wclk` in 1: write clock, the only clock.
- `wrst_n` in 1: reset, synchronous, active-low.
- `s_valid` in 1: producer data valid.
- `s_data` in DSIZE: producer data.
- `s_ready` out 1: buffer can accept (registered).
- `wfull` in 1: FIFO full, from the write-pointer block.
- `wptr` in ADDRSIZE+1: Gray write pointer, from the write-pointer block.
- `wq2_rptr` in ADDRSIZE+1: Gray read pointer, already synchronised into wclk.
- `winc` out 1: write strobe to the pointer block and memory.
- `wdata` out DSIZE: write data to memory.
- `wlevel` out ADDRSIZE+1: conservative fill level, 0..2^ADDRSIZE (registered).
- `walmost_full` out 1: `wlevel ≥ AFULL_THRESH` (registered).

## Operation
- **Skid buffer.** Two entries, strict FIFO order, occupancy `cnt` ∈ {0,1,2}.
  - Head = oldest entry; `wdata` = head data.
  - Accept = `s_valid & s_ready`.
  - Drain = `winc` = (`cnt` ≠ 0) & ~`wfull`. This is combinational from `wfull`, as the pointer block requires.
  - `cnt_next` = `cnt` + accept − drain.
  - `s_ready` ← (`cnt_next` < 2).
- **Accept and drain together.**
  - With `cnt`=1: the head is written out and the new word becomes head; `cnt` stays 1.
  - With `cnt`=2: cannot occur, because `s_ready`=0.
- **Hold while full.** While `wfull`=1, `winc`=0 and `wdata` and the head are held unchanged. Buffer contents are never dropped or reordered.
- **Data width.** `s_data` is stored unmodified; no width conversion.
- **Level.**
  - Convert both pointers Gray→binary: b[MSB]=g[MSB]; b[i]=b[i+1]^g[i].
  - `wlevel` ← (bin(`wptr`) − bin(`wq2_rptr`)) mod 2^(ADDRSIZE+1).
  - The read pointer is stale, so the level is only ever an over-estimate.
  - Pointer wrap is handled by the modular subtraction; for example `wptr` bin 2, `rptr` bin 30 (ADDRSIZE=4) gives 4.
- **Almost full.** `walmost_full` ← (level_next ≥ `AFULL_THRESH`), updated in the same cycle as `wlevel`.
- **Reset.** While `wrst_n`=0 at a `wclk` edge:
  - `cnt` ← 0, so `winc`=0.
  - Buffer data ← 0, so `wdata`=0.
  - `s_ready` ← 0, `wlevel` ← 0, `walmost_full` ← 0.
  - Reset mid-operation discards buffered words; the producer must re-send them.

## Timing
- **Ready after reset.** `s_ready` rises at the first edge with `wrst_n`=1, so it is first sampled high one cycle after reset release.
- **Empty-buffer latency.** An accept at edge N puts the word at head; `winc` asserts in cycle N+1 if `wfull`=0. Latency is 1 cycle.
- **Throughput.** Sustained 1 word/cycle with `s_valid`=1 and `wfull`=0; `cnt` settles at 1.
- **`wfull` rise.**
  - `winc` drops in the same cycle.
  - The buffer fills to 2 over at most 2 edges, then `s_ready`=0 from the next edge.
- **`wfull` fall.** `winc` reasserts in the same cycle with the held head word.
- **Level latency.** `wlevel` and `walmost_full` lag their pointer inputs by 1 cycle.
- **Combinational paths.** The only combinational input→output path is `wfull`→`winc`.

## Structure
- **Shared package / include.**
  - Gray→binary conversion function.
  - Default `ADDRSIZE`/`DSIZE` constants, shared with the pointer, synchroniser and memory blocks.
- **Sub-module `wr_skid_buf`.** Holds the 2-entry buffer, `cnt`, `s_ready` and the head mux; parameterised by DSIZE.
- **Top level.** Holds only `winc` gating, the level subtractor and the almost-full compare.

## Test plan
- **Reset release.** Hold `wrst_n`=0 for 3 edges with `s_valid`=1, then release → all outputs 0 during reset; `s_ready`=1 after the first released edge; first `winc` one cycle after the first accept.
- **Streaming.** Send 0x01..0x10 back-to-back with `wfull`=0 → `winc` high 16 consecutive cycles; `wdata` 0x01..0x10 in order; `s_ready` never low.
- **Backpressure.** Raise `wfull` mid-stream after 0x05 is written → `winc`=0 in the same cycle; 0x06, 0x07 buffered; `s_ready`=0. Lower `wfull` → 0x06, 0x07, 0x08… resume with no loss or duplication.
- **Level wrap.** Use Gray `wptr`=bin 2 and `wq2_rptr`=bin 30, ADDRSIZE=4 → `wlevel`=4, `walmost_full`=0. Then `wptr`=bin 28, `wq2_rptr`=bin 12 → `wlevel`=16, `walmost_full`=1.
- **Threshold edge.** Step the level 11→12→11 → `walmost_full` 0→1→0, each change one cycle after the pointer change.
- **Mid-operation reset.** Assert `wrst_n`=0 with `cnt`=2 and `wfull`=1 → next edge `cnt`=0, `winc`=0, `s_ready`=0; the buffered words are never written.
